eviction_write_buffer: RTL and testbench

EVICTION_WRITE_BUFFER -- requirements
Module: eviction_write_buffer

---
 rtl/lc3b_types.sv | 22 ++
 rtl/ewb_control.sv | 91 +++++++++
 rtl/eviction_write_buffer.sv | 130 +++++++++++++
 tb/tb_eviction_write_buffer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared word/line types, FSM state encoding and helper
// constants for the eviction write buffer.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_tag;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    ACK   = 2'd3
  } ewb_state_t;

  // Idle-drain counter width; covers DRAIN_DELAY values 0..15.
  localparam int EWB_CNT_W = 4;

  // Clears the byte offset so an address compares/issues as a line address.
  localparam lc3b_word EWB_LINE_MASK = 16'hFFF0;

endpackage

// File: rtl/ewb_control.sv
// ewb_control: request sequencing FSM and idle-drain counter for the
// eviction write buffer. Produces the next state plus one-cycle strobes the
// top level uses to update the entry and response registers.
// Optional feature: EWB_FORWARD_EN (read hits on the buffered line are
// answered from the buffer instead of draining first).
//
// state | meaning
// IDLE  | accepting upstream requests, counting idle cycles while dirty
// READ  | pmem_read outstanding for an upstream read miss
// DRAIN | pmem_write of the buffered line outstanding
// ACK   | one-cycle mem_resp to upstream
module ewb_control
  import lc3b_types::*;
#(
  parameter int DRAIN_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic       buf_valid,
  input  logic       buf_hit,
  input  logic       pmem_resp,
  output ewb_state_t next_state,
  output logic       buf_load,
  output logic       buf_clear,
  output logic       rdata_from_pmem,
  output logic       rdata_from_buf
);

`ifdef EWB_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam logic [EWB_CNT_W-1:0] DELAY_TC = DRAIN_DELAY[EWB_CNT_W-1:0];

  ewb_state_t           state_q, state_d;
  logic [EWB_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic                 drain_due;
  logic                 req_present;

  assign req_present = mem_read | mem_write;
  assign drain_due   = (idle_cnt_q == DELAY_TC);
  assign next_state  = state_d;

  // State register and idle-drain counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Next-state selection; a started DRAIN or READ ignores upstream until pmem_resp.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          state_d = (!buf_valid || buf_hit) ? ACK : DRAIN;
        end else if (mem_read) begin
          if (buf_hit) state_d = FWD_EN ? ACK : DRAIN;
          else         state_d = READ;
        end else if (buf_valid && drain_due) begin
          state_d = DRAIN;
        end
      end
      READ:    if (pmem_resp) state_d = ACK;
      DRAIN:   if (pmem_resp) state_d = IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes and idle-drain count; any request or leaving IDLE clears the count.
  always_comb begin
    buf_load        = (state_q == IDLE) && mem_write && (!buf_valid || buf_hit);
    buf_clear       = (state_q == DRAIN) && pmem_resp;
    rdata_from_pmem = (state_q == READ) && pmem_resp;
    rdata_from_buf  = FWD_EN && (state_q == IDLE) && !mem_write && mem_read && buf_hit;
    idle_cnt_d      = '0;
    if ((state_q == IDLE) && buf_valid && !req_present && !drain_due)
      idle_cnt_d = idle_cnt_q + 1'b1;
  end

endmodule

// File: rtl/eviction_write_buffer.sv
// eviction_write_buffer: single-line write buffer between the cache and
// physical memory. Holds one evicted line, coalesces writes to the same line
// and drains it after DRAIN_DELAY idle cycles or when a conflicting request
// needs memory. All outputs come straight from registers.
// Optional feature: EWB_FORWARD_EN (handled inside ewb_control).
module eviction_write_buffer
  import lc3b_types::*;
#(
  parameter int DRAIN_DELAY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_address,
  input  logic [127:0] mem_wdata,
  output logic         mem_resp,
  output logic [127:0] mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata
);

  logic         buf_valid_q, buf_valid_d;
  lc3b_line_tag buf_line_q, buf_line_d;
  lc3b_line     buf_data_q, buf_data_d;
  logic         mem_resp_q, mem_resp_d;
  lc3b_line     mem_rdata_q, mem_rdata_d;
  logic         pmem_read_q, pmem_read_d;
  logic         pmem_write_q, pmem_write_d;
  lc3b_word     pmem_address_q, pmem_address_d;
  lc3b_line     pmem_wdata_q, pmem_wdata_d;

  ewb_state_t   next_state;
  lc3b_word     req_line_addr;
  logic         buf_hit;
  logic         buf_load;
  logic         buf_clear;
  logic         rdata_from_pmem;
  logic         rdata_from_buf;

  assign req_line_addr = mem_address & EWB_LINE_MASK;
  assign buf_hit       = buf_valid_q && (req_line_addr == {buf_line_q, 4'b0000});

  ewb_control #(
    .DRAIN_DELAY (DRAIN_DELAY)
  ) u_ctrl (
    .clk             (clk),
    .reset           (reset),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .buf_valid       (buf_valid_q),
    .buf_hit         (buf_hit),
    .pmem_resp       (pmem_resp),
    .next_state      (next_state),
    .buf_load        (buf_load),
    .buf_clear       (buf_clear),
    .rdata_from_pmem (rdata_from_pmem),
    .rdata_from_buf  (rdata_from_buf)
  );

  // Entry update, read-data capture and registered pmem/mem request outputs.
  always_comb begin
    buf_valid_d    = buf_valid_q;
    buf_line_d     = buf_line_q;
    buf_data_d     = buf_data_q;
    mem_rdata_d    = mem_rdata_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;

    if (buf_load) begin
      buf_valid_d = 1'b1;
      buf_line_d  = req_line_addr[15:4];
      buf_data_d  = mem_wdata;
    end
    if (buf_clear) buf_valid_d = 1'b0;

    if (rdata_from_pmem)     mem_rdata_d = pmem_rdata;
    else if (rdata_from_buf) mem_rdata_d = buf_data_q;

    // The buffered line is stable through DRAIN and upstream holds its
    // address through READ, so reloading while the state holds is harmless.
    if (next_state == DRAIN) begin
      pmem_address_d = {buf_line_q, 4'b0000};
      pmem_wdata_d   = buf_data_q;
    end else if (next_state == READ) begin
      pmem_address_d = req_line_addr;
    end

    mem_resp_d   = (next_state == ACK);
    pmem_read_d  = (next_state == READ);
    pmem_write_d = (next_state == DRAIN);
  end

  // Entry and output registers; reset discards any buffered line or open transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q    <= 1'b0;
      buf_line_q     <= '0;
      buf_data_q     <= '0;
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      buf_valid_q    <= buf_valid_d;
      buf_line_q     <= buf_line_d;
      buf_data_q     <= buf_data_d;
      mem_resp_q     <= mem_resp_d;
      mem_rdata_q    <= mem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign mem_resp     = mem_resp_q;
  assign mem_rdata    = mem_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_eviction_write_buffer.sv
// tb_eviction_write_buffer: directed timing scenarios plus a randomized
// read/write mix checked against a line-granular memory model.
`timescale 1ns/1ps
module tb_eviction_write_buffer;

  localparam int DD = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [127:0] mem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  eviction_write_buffer #(.DRAIN_DELAY(DD)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- physical memory model ----------------
  logic [127:0] pmem_mem [int];
  logic [127:0] ref_mem  [int];
  logic [15:0]  pw_addr_q [$];
  logic [127:0] pw_data_q [$];
  int           pw_cyc_q  [$];
  logic [15:0]  pr_addr_q [$];
  int           pr_cyc_q  [$];
  int           pmem_lat  = 1;
  int           wr_starts = 0;
  int           rd_starts = 0;
  int           excl_viol = 0;

  function automatic logic [127:0] init_data(input logic [11:0] line);
    return {8{4'h5, line}};
  endfunction

  function automatic logic [127:0] pmem_peek(input logic [11:0] line);
    if (pmem_mem.exists(int'(line))) return pmem_mem[int'(line)];
    return init_data(line);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Responds pmem_lat cycles after a request is first seen (0 = same cycle).
  initial begin : pmem_responder
    int  wcnt;
    int  cur_lat;
    bit  busy;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    wcnt = 0; cur_lat = 0; busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) excl_viol++;
      if (reset) begin
        busy = 1'b0;
      end else if (pmem_read || pmem_write) begin
        if (!busy) begin
          busy = 1'b1; wcnt = 0; cur_lat = pmem_lat;
          if (pmem_write) wr_starts++; else rd_starts++;
        end
        if (wcnt >= cur_lat) begin
          pmem_resp = 1'b1;
          busy = 1'b0;
          if (pmem_write) begin
            pmem_mem[int'(pmem_address[15:4])] = pmem_wdata;
            pw_addr_q.push_back(pmem_address);
            pw_data_q.push_back(pmem_wdata);
            pw_cyc_q.push_back(cyc);
          end else begin
            pmem_rdata = pmem_peek(pmem_address[15:4]);
            pr_addr_q.push_back(pmem_address);
            pr_cyc_q.push_back(cyc);
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // ---------------- upstream driver ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_req(input bit wr, input logic [15:0] addr, input logic [127:0] data,
                        input string tag, output logic [127:0] rdata, output int lat,
                        output int resp_cyc);
    int n;
    n = 0;
    mem_address = addr;
    mem_wdata   = data;
    mem_write   = wr;
    mem_read    = !wr;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (mem_resp) break;
    end
    check_eq({tag, "_resp"}, mem_resp, 1'b1);
    rdata     = mem_rdata;
    lat       = n;
    resp_cyc  = cyc;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic wait_pw(output int n);
    n = 0;
    while (!pmem_write && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("pw_seen", pmem_write, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic [11:0]  rnd_lines [3] = '{12'hA01, 12'hA02, 12'hA03};

  initial begin : main
    logic [127:0] rd, a_d, b_d, c_d, exp_d, wd;
    logic [11:0]  ln;
    int           lat, rc, n, pw0, pr0, ws0, rs0;

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = '0; mem_wdata = '0;
    idle(3);
    check_eq("rst_mem_resp",   mem_resp,     1'b0);
    check_eq("rst_pmem_read",  pmem_read,    1'b0);
    check_eq("rst_pmem_write", pmem_write,   1'b0);
    check_eq("rst_pmem_addr",  pmem_address, 16'h0);
    check_eq("rst_pmem_wdata", pmem_wdata,   128'h0);
    check_eq("rst_mem_rdata",  mem_rdata,    128'h0);
    reset = 1'b0;
    idle(2);

    // Write to empty buffer: ack next cycle, drain after the idle window.
    a_d = rand128(); pmem_lat = 1; pw0 = pw_addr_q.size(); rs0 = rd_starts;
    do_req(1'b1, 16'h1230, a_d, "t1_wr", rd, lat, rc);
    check_eq("t1_lat", lat, 1);
    check_eq("t1_no_pmem", {pmem_read, pmem_write}, 2'b00);
    wait_pw(n);
    // one edge out of ACK, DD counted idle cycles, then the triggering edge
    check_eq("t1_drain_delay", n, DD + 2);
    check_eq("t1_pw_addr", pmem_address, 16'h1230);
    check_eq("t1_pw_data", pmem_wdata, a_d);
    idle(5);
    check_eq("t1_pw_count", pw_addr_q.size() - pw0, 1);
    check_eq("t1_no_pread", rd_starts - rs0, 0);
    idle(10);

    // Coalesce: second write to the same line overwrites, one drain of B.
    a_d = rand128(); b_d = rand128(); pw0 = pw_addr_q.size();
    do_req(1'b1, 16'h1230, a_d, "t2_wr1", rd, lat, rc);
    idle(1);
    do_req(1'b1, 16'h1238, b_d, "t2_wr2", rd, lat, rc);
    check_eq("t2_coalesce_lat", lat, 1);
    idle(20);
    check_eq("t2_pw_count", pw_addr_q.size() - pw0, 1);
    check_eq("t2_pw_addr", pw_addr_q[$], 16'h1230);
    check_eq("t2_pw_data", pw_data_q[$], b_d);

    // Conflicting write: old line drains before the new write is acked.
    a_d = rand128(); c_d = rand128(); pmem_lat = 3; pw0 = pw_addr_q.size();
    do_req(1'b1, 16'h1230, a_d, "t3_wr1", rd, lat, rc);
    idle(1);
    do_req(1'b1, 16'h4560, c_d, "t3_wr2", rd, lat, rc);
    check_eq("t3_lat", lat, 3 + 3);
    check_eq("t3_evict_cnt", pw_addr_q.size() - pw0, 1);
    check_eq("t3_evict_addr", pw_addr_q[$], 16'h1230);
    check_eq("t3_evict_data", pw_data_q[$], a_d);
    check_eq("t3_evict_first", pw_cyc_q[$] < rc, 1'b1);
    wait_pw(n);
    check_eq("t3_new_addr", pmem_address, 16'h4560);
    check_eq("t3_new_data", pmem_wdata, c_d);
    idle(20);

    // Read hitting the buffered line.
    a_d = rand128(); pmem_lat = 1; pw0 = pw_addr_q.size(); pr0 = pr_addr_q.size();
    do_req(1'b1, 16'h1230, a_d, "t4_wr", rd, lat, rc);
    idle(1);
    do_req(1'b0, 16'h1234, '0, "t4_rd", rd, lat, rc);
    check_eq("t4_rdata", rd, a_d);
`ifdef EWB_FORWARD_EN
    check_eq("t4_fwd_lat", lat, 1);
    check_eq("t4_fwd_no_pread", pr_addr_q.size() - pr0, 0);
`else
    check_eq("t4_drain_cnt", pw_addr_q.size() - pw0, 1);
    check_eq("t4_read_cnt", pr_addr_q.size() - pr0, 1);
    check_eq("t4_order", pw_cyc_q[$] < pr_cyc_q[$], 1'b1);
`endif
    idle(20);

    // Read miss with slow memory.
    pmem_lat = 5;
    do_req(1'b0, 16'h8000, '0, "t5_rd", rd, lat, rc);
    check_eq("t5_lat", lat, 5 + 2);
    check_eq("t5_resp_after_presp", rc - pr_cyc_q[$], 1);
    check_eq("t5_paddr", pr_addr_q[$], 16'h8000);
    check_eq("t5_rdata", rd, init_data(12'h800));
    idle(5);

    // Reset in the middle of a drain abandons it and drops the line.
    a_d = rand128(); pmem_lat = 10; pw0 = pw_addr_q.size();
    do_req(1'b1, 16'h1230, a_d, "t6_wr", rd, lat, rc);
    wait_pw(n);
    idle(2);
    ws0 = wr_starts;
    reset = 1'b1;
    idle(1);
    check_eq("t6_pw_low", pmem_write, 1'b0);
    check_eq("t6_resp_low", mem_resp, 1'b0);
    check_eq("t6_rdata_rst", mem_rdata, 128'h0);
    reset = 1'b0; pmem_lat = 1;
    idle(20);
    check_eq("t6_no_redrain", wr_starts - ws0, 0);
    check_eq("t6_no_pw_done", pw_addr_q.size() - pw0, 0);

    // Random mix over a few lines; reads must see the latest upstream write.
    for (int i = 0; i < 150; i++) begin
      pmem_lat = $urandom_range(0, 4);
      idle($urandom_range(0, 3));
      ln = rnd_lines[$urandom_range(0, 2)];
      if ($urandom_range(0, 1) == 1) begin
        wd = rand128();
        ref_mem[int'(ln)] = wd;
        do_req(1'b1, {ln, 4'($urandom_range(0, 15))}, wd, "rnd_wr", rd, lat, rc);
      end else begin
        exp_d = ref_mem.exists(int'(ln)) ? ref_mem[int'(ln)] : init_data(ln);
        do_req(1'b0, {ln, 4'($urandom_range(0, 15))}, '0, "rnd_rd", rd, lat, rc);
        check_eq("rnd_rdata", rd, exp_d);
      end
    end
    idle(40);
    for (int j = 0; j < 3; j++) begin
      if (ref_mem.exists(int'(rnd_lines[j])))
        check_eq("rnd_flushed", pmem_peek(rnd_lines[j]), ref_mem[int'(rnd_lines[j])]);
    end
    check_eq("pmem_exclusive", excl_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
